// File: rtl/cache_regfile_pkg.sv
// Shared types and helpers for the cache register file.
//   crf_state_t : clear-engine state (IDLE, CLEAR)
//   crf_addr_w  : address width for a given entry count, never below 1 bit
package cache_regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } crf_state_t;

   function automatic int crf_addr_w(input int depth);
      if (depth <= 2) return 1;
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/cache_register_entry.sv
// One row of the cache register file.
// Ports:
//   clk_i   : clock, updates on posedge
//   rst_ni  : asynchronous active-low reset, row goes to 0
//   clr_i   : synchronous clear, wins over ld_i
//   ld_i    : load enable, captures d_i
//   d_i     : load data
//   q_o     : stored value
module cache_register_entry #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (clr_i) begin
         data_d = '0;
      end else if (ld_i) begin
         data_d = d_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/cache_register_file.sv
// Bank of DEPTH load-enabled registers, WIDTH bits each, with one write port,
// two registered read ports (write-first bypass) and a sequenced bulk clear.
// Ports:
//   CLK, RST_N           : clock; asynchronous active-low reset
//   wr_en/wr_addr/wr_data: write port, out-of-range addresses are dropped
//   rd_en_x/rd_addr_x    : read request for port x (a or b)
//   rd_data_x/rd_vld_x   : registered read result and its 1-cycle valid pulse
//   clr_req              : start a bulk clear (ignored while one is running)
//   busy                 : clear engine running
//   dbg_state            : current clear-engine state
//
// Read handshake: a request is taken on the posedge where rd_en_x=1, the engine
// is idle and no clear is being accepted; exactly one cycle later rd_vld_x
// pulses for one cycle with rd_data_x. There is no back-pressure. Requests not
// taken produce no pulse, and rd_data_x holds its previous value.
module cache_register_file
   import cache_regfile_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = crf_addr_w(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en_a,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [WIDTH-1:0]  rd_data_a,
   output logic              rd_vld_a,
   input  logic              rd_en_b,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_b,
   output logic              rd_vld_b,
   input  logic              clr_req,
   output logic              busy,
   output crf_state_t        dbg_state
);

   // One extra bit so DEPTH itself is representable for the range check.
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

   crf_state_t        state_q, state_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

   logic [WIDTH-1:0]  entry_q [DEPTH];
   logic [DEPTH-1:0]  clr_sel;
   logic [DEPTH-1:0]  ld_sel;

   logic              idle;
   logic              wr_ok;
   logic              rd_ok_a;
   logic              rd_ok_b;

   logic [WIDTH-1:0]  rd_data_a_q, rd_data_a_d;
   logic [WIDTH-1:0]  rd_data_b_q, rd_data_b_d;
   logic              rd_vld_a_q, rd_vld_b_q;

   // A cycle that accepts clr_req is already owned by the clear: its write and
   // reads are discarded along with everything else.
   assign idle    = (state_q == IDLE);
   assign wr_ok   = idle && !clr_req && wr_en && ({1'b0, wr_addr} < DEPTH_EXT);
   assign rd_ok_a = idle && !clr_req && rd_en_a;
   assign rd_ok_b = idle && !clr_req && rd_en_b;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d   = CLEAR;
               clr_idx_d = '0;
            end
         end
         CLEAR: begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            if (clr_idx_q == LAST_IDX) begin
               state_d   = IDLE;
               clr_idx_d = '0;
            end
         end
         default: begin
            state_d   = IDLE;
            clr_idx_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   assign busy      = (state_q == CLEAR);
   assign dbg_state = state_q;

   // ---------------------------------------------------------------- entries
   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      assign clr_sel[g] = (state_q == CLEAR) && (clr_idx_q == ADDR_W'(g));
      assign ld_sel[g]  = wr_ok && (wr_addr == ADDR_W'(g));

      cache_register_entry #(
         .WIDTH (WIDTH)
      ) u_entry (
         .clk_i  (CLK),
         .rst_ni (RST_N),
         .clr_i  (clr_sel[g]),
         .ld_i   (ld_sel[g]),
         .d_i    (wr_data),
         .q_o    (entry_q[g])
      );
   end

   // ---------------------------------------------------------------- reads
   // Out-of-range addresses match no entry and can never be written, so they
   // fall through to 0. An accepted write to the same address wins.
   function automatic logic [WIDTH-1:0] read_value(input logic [ADDR_W-1:0] addr);
      logic [WIDTH-1:0] val;
      val = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr == ADDR_W'(i)) val = entry_q[i];
      end
      if (wr_ok && (wr_addr == addr)) val = wr_data;
      return val;
   endfunction

   always_comb begin
      rd_data_a_d = rd_data_a_q;
      rd_data_b_d = rd_data_b_q;
      if (rd_ok_a) rd_data_a_d = read_value(rd_addr_a);
      if (rd_ok_b) rd_data_b_d = read_value(rd_addr_b);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         rd_vld_a_q  <= 1'b0;
         rd_vld_b_q  <= 1'b0;
      end else begin
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
         rd_vld_a_q  <= rd_ok_a;
         rd_vld_b_q  <= rd_ok_b;
      end
   end

   assign rd_data_a = rd_data_a_q;
   assign rd_data_b = rd_data_b_q;
   assign rd_vld_a  = rd_vld_a_q;
   assign rd_vld_b  = rd_vld_b_q;

endmodule
